// File: rtl/mem_arb_pkg.sv
// Shared types and grant encodings for the two-requester memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response handshake bundle shared by the fetch, memory-stage and bus ports.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                req;
    logic                wr;
    logic [DATA_W/8-1:0] wstrb;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic                addr_ok;
    logic                data_ok;
    logic [DATA_W-1:0]   rdata;

    // Side that issues requests.
    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    // Side that accepts requests.
    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

    // Read-only acceptor view used for the instruction-fetch requester.
    modport fetch (
        input  req, addr,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: the requester not granted last wins a tie.
import mem_arb_pkg::*;

module mem_arb_pick (
    input  logic inst_req_i,
    input  logic data_req_i,
    input  logic last_gnt_i,
    output logic gnt_o
);

    always_comb begin
        gnt_o = GNT_INST;
        if (inst_req_i && data_req_i) begin
            gnt_o = (last_gnt_i == GNT_INST) ? GNT_DATA : GNT_INST;
        end else if (data_req_i) begin
            gnt_o = GNT_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and memory-stage requests onto one shared memory port, one transaction at a time.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; otherwise data always beats inst.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_arbiter_if.fetch       inst_i,
    mem_arbiter_if.slave       data_i,
    mem_arbiter_if.master      bus_o,
    output logic               busy_o
);

    state_t              state_q;
    logic                gnt_q;
    logic                bus_req_q;
    logic                busy_q;
    logic                wr_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                wr_d;
    logic [DATA_W/8-1:0] wstrb_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

    logic pick_gnt;
    logic last_gnt;
    logic addr_acc;
    logic data_acc;

`ifdef MEM_ARBITER_RR_EN
    // gnt_q only changes when a new transaction is accepted, so it doubles as the last-grant pointer.
    assign last_gnt = gnt_q;
`else
    // Pinning the pointer to inst makes the round-robin picker degenerate to fixed data priority.
    assign last_gnt = GNT_INST;
`endif

    mem_arb_pick u_pick (
        .inst_req_i (inst_i.req),
        .data_req_i (data_i.req),
        .last_gnt_i (last_gnt),
        .gnt_o      (pick_gnt)
    );

    always_comb begin
        wr_d    = 1'b0;
        wstrb_d = '0;
        addr_d  = inst_i.addr;
        wdata_d = '0;
        if (pick_gnt == GNT_DATA) begin
            wr_d    = data_i.wr;
            wstrb_d = data_i.wstrb;
            addr_d  = data_i.addr;
            wdata_d = data_i.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_INST;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
            wr_q      <= 1'b0;
            wstrb_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inst_i.req || data_i.req) begin
                        state_q   <= ADDR;
                        gnt_q     <= pick_gnt;
                        bus_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        wr_q      <= wr_d;
                        wstrb_q   <= wstrb_d;
                        addr_q    <= addr_d;
                        wdata_q   <= wdata_d;
                    end
                end
                ADDR: begin
                    if (bus_o.addr_ok) begin
                        state_q   <= RESP;
                        bus_req_q <= 1'b0;
                    end
                end
                RESP: begin
                    if (bus_o.data_ok) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    bus_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Handshake pulses are qualified by state so stray bus strobes in other states are ignored.
    assign addr_acc = (state_q == ADDR) && bus_o.addr_ok;
    assign data_acc = (state_q == RESP) && bus_o.data_ok;

    assign inst_i.addr_ok = addr_acc && (gnt_q == GNT_INST);
    assign inst_i.data_ok = data_acc && (gnt_q == GNT_INST);
    assign inst_i.rdata   = bus_o.rdata;
    assign data_i.addr_ok = addr_acc && (gnt_q == GNT_DATA);
    assign data_i.data_ok = data_acc && (gnt_q == GNT_DATA);
    assign data_i.rdata   = bus_o.rdata;

    assign bus_o.req   = bus_req_q;
    assign bus_o.wr    = wr_q;
    assign bus_o.wstrb = wstrb_q;
    assign bus_o.addr  = addr_q;
    assign bus_o.wdata = wdata_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter; expectations follow MEM_ARBITER_RR_EN when it is defined.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   failures = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_bus ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .inst_i (inst_bus),
        .data_i (data_bus),
        .bus_o  (mem_bus),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    // The fetch port never writes; tie off its unused write fields.
    assign inst_bus.wr    = 1'b0;
    assign inst_bus.wstrb = '0;
    assign inst_bus.wdata = '0;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Start a new cycle just after the rising edge and drive the bus-side responses.
    task automatic applyStimulus(input logic addrOk, input logic dataOk, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        mem_bus.addr_ok = addrOk;
        mem_bus.data_ok = dataOk;
        mem_bus.rdata   = rdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic setData(input logic req, input logic wr, input logic [3:0] strb,
                           input logic [31:0] addr, input logic [31:0] wdata);
        data_bus.req   = req;
        data_bus.wr    = wr;
        data_bus.wstrb = strb;
        data_bus.addr  = addr;
        data_bus.wdata = wdata;
    endtask

    logic expData;
    int   addrPulses;
    int   dataPulses;

    initial begin
        inst_bus.req    = 1'b0;
        inst_bus.addr   = '0;
        setData(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        mem_bus.addr_ok = 1'b0;
        mem_bus.data_ok = 1'b0;
        mem_bus.rdata   = '0;

        // Reset state, with stray bus strobes present.
        #2;
        mem_bus.addr_ok = 1'b1;
        mem_bus.data_ok = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_bus_req", mem_bus.req, 0);
        checkOutput("rst_bus_addr", mem_bus.addr, 0);
        checkOutput("rst_inst_addr_ok", inst_bus.addr_ok, 0);
        checkOutput("rst_data_data_ok", data_bus.data_ok, 0);

        // Lone instruction read with minimum latency.
        applyStimulus(1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        inst_bus.req  = 1'b1;
        inst_bus.addr = 32'hBFC00000;
        @(negedge clk);
        checkOutput("lone_c0_bus_req", mem_bus.req, 0);
        checkOutput("lone_c0_busy", busy, 0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("lone_c1_bus_req", mem_bus.req, 1);
        checkOutput("lone_c1_bus_addr", mem_bus.addr, 32'hBFC00000);
        checkOutput("lone_c1_bus_wr", mem_bus.wr, 0);
        checkOutput("lone_c1_inst_addr_ok", inst_bus.addr_ok, 1);
        checkOutput("lone_c1_data_addr_ok", data_bus.addr_ok, 0);
        checkOutput("lone_c1_inst_data_ok", inst_bus.data_ok, 0);
        checkOutput("lone_c1_busy", busy, 1);
        applyStimulus(1'b0, 1'b1, 32'h3C080001);
        inst_bus.req = 1'b0;
        @(negedge clk);
        checkOutput("lone_c2_bus_req", mem_bus.req, 0);
        checkOutput("lone_c2_inst_data_ok", inst_bus.data_ok, 1);
        checkOutput("lone_c2_inst_rdata", inst_bus.rdata, 32'h3C080001);
        checkOutput("lone_c2_inst_addr_ok", inst_bus.addr_ok, 0);
        checkOutput("lone_c2_data_data_ok", data_bus.data_ok, 0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("lone_c3_busy", busy, 0);
        checkOutput("lone_c3_inst_data_ok", inst_bus.data_ok, 0);

        // Simultaneous requests: data write goes first, inst after one IDLE cycle.
        inst_bus.req  = 1'b1;
        inst_bus.addr = 32'hBFC00004;
        setData(1'b1, 1'b1, 4'hF, 32'h80000010, 32'h12345678);
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("sim_bus_addr", mem_bus.addr, 32'h80000010);
        checkOutput("sim_bus_wr", mem_bus.wr, 1);
        checkOutput("sim_bus_wstrb", mem_bus.wstrb, 32'hF);
        checkOutput("sim_bus_wdata", mem_bus.wdata, 32'h12345678);
        checkOutput("sim_data_addr_ok", data_bus.addr_ok, 1);
        checkOutput("sim_inst_addr_ok", inst_bus.addr_ok, 0);
        applyStimulus(1'b0, 1'b1, 32'hDEADBEEF);
        data_bus.req = 1'b0;
        @(negedge clk);
        checkOutput("sim_data_data_ok", data_bus.data_ok, 1);
        checkOutput("sim_inst_data_ok", inst_bus.data_ok, 0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("sim_gap_bus_req", mem_bus.req, 0);
        checkOutput("sim_gap_busy", busy, 0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("sim2_bus_addr", mem_bus.addr, 32'hBFC00004);
        checkOutput("sim2_bus_wr", mem_bus.wr, 0);
        checkOutput("sim2_inst_addr_ok", inst_bus.addr_ok, 1);
        applyStimulus(1'b0, 1'b1, 32'h24090002);
        inst_bus.req = 1'b0;
        @(negedge clk);
        checkOutput("sim2_inst_data_ok", inst_bus.data_ok, 1);
        checkOutput("sim2_inst_rdata", inst_bus.rdata, 32'h24090002);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Both requesters held for four transactions.
        inst_bus.req = 1'b1;
        setData(1'b1, 1'b1, 4'hF, 32'h80000010, 32'h12345678);
        for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARBITER_RR_EN
            expData = (t % 2 == 0);
`else
            expData = 1'b1;
`endif
            @(negedge clk);
            checkOutput($sformatf("held%0d_idle_bus_req", t), mem_bus.req, 0);
            applyStimulus(1'b1, 1'b0, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("held%0d_data_addr_ok", t), data_bus.addr_ok, expData);
            checkOutput($sformatf("held%0d_inst_addr_ok", t), inst_bus.addr_ok, !expData);
            checkOutput($sformatf("held%0d_bus_addr", t), mem_bus.addr,
                        expData ? 32'h80000010 : 32'hBFC00004);
            applyStimulus(1'b0, 1'b1, 32'h11110000 + t);
            @(negedge clk);
            checkOutput($sformatf("held%0d_data_data_ok", t), data_bus.data_ok, expData);
            checkOutput($sformatf("held%0d_inst_data_ok", t), inst_bus.data_ok, !expData);
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        inst_bus.req = 1'b0;
        setData(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Bus stalls: addr_ok late by 3 cycles, data_ok late by 5, with ignored stray strobes.
        addrPulses = 0;
        dataPulses = 0;
        setData(1'b1, 1'b0, 4'h0, 32'h80000020, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("stallA%0d_bus_req", c), mem_bus.req, 1);
            checkOutput($sformatf("stallA%0d_bus_addr", c), mem_bus.addr, 32'h80000020);
            checkOutput($sformatf("stallA%0d_busy", c), busy, 1);
            addrPulses += int'(data_bus.addr_ok);
            dataPulses += int'(data_bus.data_ok);
            applyStimulus(c == 2, c == 1, 32'h0);
        end
        @(negedge clk);
        checkOutput("stallA_accept_addr_ok", data_bus.addr_ok, 1);
        addrPulses += int'(data_bus.addr_ok);
        dataPulses += int'(data_bus.data_ok);
        applyStimulus(1'b1, 1'b0, 32'h0);
        data_bus.req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("stallR%0d_bus_req", c), mem_bus.req, 0);
            checkOutput($sformatf("stallR%0d_busy", c), busy, 1);
            addrPulses += int'(data_bus.addr_ok);
            dataPulses += int'(data_bus.data_ok);
            if (c < 4) applyStimulus(c == 0, 1'b0, 32'h0);
            else applyStimulus(1'b0, 1'b1, 32'hCAFEF00D);
        end
        @(negedge clk);
        checkOutput("stallR_done_rdata", data_bus.rdata, 32'hCAFEF00D);
        addrPulses += int'(data_bus.addr_ok);
        dataPulses += int'(data_bus.data_ok);
        checkOutput("stall_addr_pulses", addrPulses, 1);
        checkOutput("stall_data_pulses", dataPulses, 1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("stall_end_busy", busy, 0);

        // Reset asserted in RESP abandons the transaction.
        inst_bus.req  = 1'b1;
        inst_bus.addr = 32'hBFC00008;
        applyStimulus(1'b1, 1'b0, 32'h0);
        inst_bus.req = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("rstm_resp_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstm_during_bus_req", mem_bus.req, 0);
        checkOutput("rstm_during_busy", busy, 0);
        checkOutput("rstm_during_bus_addr", mem_bus.addr, 0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h55AA55AA);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstm_after_inst_data_ok", inst_bus.data_ok, 0);
        checkOutput("rstm_after_data_data_ok", data_bus.data_ok, 0);
        checkOutput("rstm_after_busy", busy, 0);
        checkOutput("rstm_after_bus_req", mem_bus.req, 0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("rstm_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
